// File: rtl/mem_bus_if.sv
// Request/acknowledge data-memory bus between the MEM stage and the data memory.
interface mem_bus_if;
  logic        BUS_REQ;
  logic [31:0] BUS_ADDR;
  logic        BUS_WRITE;
  logic [3:0]  BUS_BE;
  logic [31:0] BUS_WDATA;
  logic        BUS_ACK;
  logic [31:0] BUS_RDATA;

  modport master (
    output BUS_REQ, BUS_ADDR, BUS_WRITE, BUS_BE, BUS_WDATA,
    input  BUS_ACK, BUS_RDATA
  );

  modport slave (
    input  BUS_REQ, BUS_ADDR, BUS_WRITE, BUS_BE, BUS_WDATA,
    output BUS_ACK, BUS_RDATA
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues req/ack bus transactions, steers store lanes,
// extends load data and stalls the pipeline until each access finishes.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] Address_IN,
  input  logic [31:0] MemWriteData_IN,
  input  logic [5:0]  MemControl_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  output logic        STALL_OUT,
  mem_bus_if.master   bus,
  output logic [31:0] MemReadData_OUT,
  output logic        ADDR_ERROR,
  output logic        BUS_ERROR
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  size_e            size_q;
  logic             sign_q;
  logic [1:0]       lane_q;

  size_e       size_c;
  logic        sign_c;
  logic        access_c;
  logic        aligned_c;
  logic [1:0]  lane_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Opcode decode, alignment and store lane steering from the live EXE/MEM inputs
  always_comb begin
    size_c    = SZ_WORD;
    sign_c    = 1'b0;
    access_c  = MemRead_IN | MemWrite_IN;
    lane_c    = Address_IN[1:0];
    aligned_c = 1'b0;
    be_c      = 4'b1111;
    wdata_c   = MemWriteData_IN;

    case (MemControl_IN)
      OP_LB:         begin size_c = SZ_BYTE; sign_c = 1'b1; end
      OP_LBU, OP_SB: size_c = SZ_BYTE;
      OP_LH:         begin size_c = SZ_HALF; sign_c = 1'b1; end
      OP_LHU, OP_SH: size_c = SZ_HALF;
      default:       size_c = SZ_WORD;
    endcase

    case (size_c)
      SZ_BYTE: aligned_c = 1'b1;
      SZ_HALF: aligned_c = ~lane_c[0];
      default: aligned_c = (lane_c == 2'b00);
    endcase

    if (MemWrite_IN) begin
      case (size_c)
        SZ_BYTE: begin
          be_c    = 4'b1000 >> lane_c;
          wdata_c = {4{MemWriteData_IN[7:0]}};
        end
        SZ_HALF: begin
          be_c    = lane_c[1] ? 4'b0011 : 4'b1100;
          wdata_c = {2{MemWriteData_IN[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = MemWriteData_IN;
        end
      endcase
    end
  end

  // Big-endian lane extraction of the returned word using the held access attributes
  always_comb begin
    byte_c = 8'h00;
    half_c = 16'h0000;
    ext_c  = bus.BUS_RDATA;

    case (lane_q)
      2'd0:    byte_c = bus.BUS_RDATA[31:24];
      2'd1:    byte_c = bus.BUS_RDATA[23:16];
      2'd2:    byte_c = bus.BUS_RDATA[15:8];
      default: byte_c = bus.BUS_RDATA[7:0];
    endcase
    half_c = lane_q[1] ? bus.BUS_RDATA[15:0] : bus.BUS_RDATA[31:16];

    case (size_q)
      SZ_BYTE: ext_c = {{24{sign_q & byte_c[7]}}, byte_c};
      SZ_HALF: ext_c = {{16{sign_q & half_c[15]}}, half_c};
      default: ext_c = bus.BUS_RDATA;
    endcase
  end

  // Stall must rise in the same cycle the access appears, so these decode live state
  assign STALL_OUT  = RESET && ((state_q == IDLE && access_c && aligned_c) || state_q == BUSY);
  assign ADDR_ERROR = RESET && state_q == IDLE && access_c && !aligned_c;
  assign BUS_ERROR  = state_q == BUSY && !bus.BUS_ACK && cnt_q == CNT_W'(TIMEOUT);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      size_q          <= SZ_BYTE;
      sign_q          <= 1'b0;
      lane_q          <= 2'b00;
      bus.BUS_REQ     <= 1'b0;
      bus.BUS_ADDR    <= '0;
      bus.BUS_WRITE   <= 1'b0;
      bus.BUS_BE      <= '0;
      bus.BUS_WDATA   <= '0;
      MemReadData_OUT <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_c && aligned_c) begin
            state_q       <= BUSY;
            cnt_q         <= CNT_W'(1);
            size_q        <= size_c;
            sign_q        <= sign_c;
            lane_q        <= lane_c;
            bus.BUS_REQ   <= 1'b1;
            bus.BUS_ADDR  <= {Address_IN[31:2], 2'b00};
            bus.BUS_WRITE <= MemWrite_IN;
            bus.BUS_BE    <= be_c;
            bus.BUS_WDATA <= wdata_c;
          end else if (access_c) begin
            MemReadData_OUT <= '0;
          end
        end
        BUSY: begin
          // An ack in the final counted cycle still completes normally
          if (bus.BUS_ACK) begin
            if (!bus.BUS_WRITE) MemReadData_OUT <= ext_c;
            bus.BUS_REQ <= 1'b0;
            state_q     <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            MemReadData_OUT <= '0;
            bus.BUS_REQ     <= 1'b0;
            state_q         <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
